// File: rtl/pe_pkg.sv
// Shared constants, FSM state encoding and opcode legality check for the PE issue arbiter.
package pe_pkg;

    localparam logic [6:0] OPC_ARITH = 7'b0000001;
    localparam logic [4:0] FUNC_ADD  = 5'd1;
    localparam logic [4:0] FUNC_SUB  = 5'd2;
    localparam logic [4:0] FUNC_MUL  = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Only the major opcode (bits 31:25) and function field (bits 24:20) decide legality.
    function automatic logic op_is_legal(input logic [6:0] major, input logic [4:0] func);
        return (major == OPC_ARITH) &&
               ((func == FUNC_ADD) || (func == FUNC_SUB) || (func == FUNC_MUL));
    endfunction

endpackage

// File: rtl/pe_issue_arbiter_if.sv
// Requester, PE and response signals of the PE issue arbiter.
// slave = arbiter view, master = environment (issue queues, PE, response sink).
interface pe_issue_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_opcode;
    logic [32*NREQ-1:0] req_op1;
    logic [32*NREQ-1:0] req_op2;

    logic [31:0]        pe_opcode;
    logic [31:0]        pe_op1;
    logic [31:0]        pe_op2;
    logic [31:0]        pe_result;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_err;

    modport slave (
        input  req_valid, req_opcode, req_op1, req_op2, pe_result, rsp_ready,
        output req_ready, pe_opcode, pe_op1, pe_op2, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_opcode, req_op1, req_op2, pe_result, rsp_ready,
        input  req_ready, pe_opcode, pe_op1, pe_op2, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request after the pointer, wrapping mod NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int pos;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = (int'(ptr_i) + k) % NREQ;
            if (req_i[pos]) begin
                gnt_o = NREQ'(1) << pos;
                idx_o = IDW'(pos);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_issue_arbiter.sv
// Shares one PE among NREQ requesters: round-robin grant, issue, wait PE_LAT, tagged response.
// Optional build macro PE_ARB_PERF_EN adds saturating legal/illegal grant counters.
module pe_issue_arbiter
    import pe_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int PE_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    pe_issue_arbiter_if.slave bus,
    output logic              busy
`ifdef PE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_err_cnt
`endif
);

    localparam int CNTW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [31:0]     opc_q, opc_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]     opc_arr [NREQ];
    logic [31:0]     op1_arr [NREQ];
    logic [31:0]     op2_arr [NREQ];

    logic [NREQ-1:0] gnt_vec;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            grant_en;
    logic            grant;
    logic            win_legal;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign opc_arr[gi] = bus.req_opcode[32*gi +: 32];
        assign op1_arr[gi] = bus.req_op1[32*gi +: 32];
        assign op2_arr[gi] = bus.req_op2[32*gi +: 32];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt_vec),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Grants happen only from IDLE or from an accepted response; never while reset is held.
    assign grant_en  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));
    assign grant     = grant_en && gnt_any;
    assign win_legal = op_is_legal(opc_arr[gnt_idx][31:25], opc_arr[gnt_idx][24:20]);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        opc_d      = opc_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: ;
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = CNTW'(PE_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = bus.pe_result;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A grant overrides the plain transitions of IDLE/RESP above.
        if (grant) begin
            rr_d  = gnt_idx;
            id_d  = gnt_idx;
            opc_d = opc_arr[gnt_idx];
            op1_d = op1_arr[gnt_idx];
            op2_d = op2_arr[gnt_idx];
            if (win_legal) begin
                state_d   = ST_ISSUE;
                rsp_err_d = 1'b0;
            end else begin
                state_d    = ST_RESP;
                rsp_err_d  = 1'b1;
                rsp_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= IDW'(NREQ - 1);
            id_q       <= '0;
            opc_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            opc_q      <= opc_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant_en ? gnt_vec : '0;
    assign bus.pe_opcode = (state_q == ST_ISSUE) ? opc_q : '0;
    assign bus.pe_op1    = (state_q == ST_ISSUE) ? op1_q : '0;
    assign bus.pe_op2    = (state_q == ST_ISSUE) ? op2_q : '0;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef PE_ARB_PERF_EN
    logic [31:0] perf_issue_q;
    logic [31:0] perf_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_err_q   <= '0;
        end else if (grant) begin
            if (win_legal) begin
                if (perf_issue_q != '1) perf_issue_q <= perf_issue_q + 32'd1;
            end else begin
                if (perf_err_q != '1) perf_err_q <= perf_err_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_err_cnt   = perf_err_q;
`endif

endmodule

// File: tb/tb_pe_issue_arbiter.sv
// Directed bench for pe_issue_arbiter: vector table of single ops plus round-robin,
// backpressure, mid-op reset and (with PE_ARB_PERF_EN) counter sequences.
module tb_pe_issue_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [31:0] OP_ADD = 32'h0210_0000;
    localparam logic [31:0] OP_SUB = 32'h0220_0000;
    localparam logic [31:0] OP_MUL = 32'h0230_0000;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef PE_ARB_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_issue_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    pe_issue_arbiter #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .PE_LAT (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .busy           (busy)
`ifdef PE_ARB_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_err_cnt   (perf_err_cnt)
`endif
    );

    // PE model: one registered stage computing on whatever is presented.
    always @(posedge clk) begin
        case (bus.pe_opcode[24:20])
            5'd1:    bus.pe_result <= bus.pe_op1 + bus.pe_op2;
            5'd2:    bus.pe_result <= bus.pe_op1 - bus.pe_op2;
            5'd3:    bus.pe_result <= bus.pe_op1 * bus.pe_op2;
            default: bus.pe_result <= 32'h0;
        endcase
    end

    typedef struct {
        int          id;
        logic [31:0] opc;
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] opc, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_valid[id]           = 1'b1;
        bus.req_opcode[32*id +: 32] = opc;
        bus.req_op1[32*id +: 32]    = a;
        bus.req_op2[32*id +: 32]    = b;
    endtask

    task automatic clr_req(input int id);
        bus.req_valid[id] = 1'b0;
    endtask

    // Called right after a negedge; returns at the sample point of the grant cycle.
    task automatic wait_grant(input int id, output bit got);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            #1;
            if (bus.req_ready == (NREQ'(1) << id)) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic run_op(input string nm, input int id, input logic [31:0] opc,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic exp_err, input logic [31:0] exp_data);
        bit got;
        @(negedge clk);
        set_req(id, opc, a, b);
        wait_grant(id, got);
        chk({nm, " grant"}, 32'(got), 32'd1);
        if (!got) begin
            clr_req(id);
            return;
        end
        @(negedge clk);
        clr_req(id);
        #1;
        if (exp_err) begin
            chk({nm, " pe_opcode idle"}, bus.pe_opcode, 32'h0);
        end else begin
            chk({nm, " pe_opcode issue"}, bus.pe_opcode, opc);
            chk({nm, " pe_op1 issue"}, bus.pe_op1, a);
            chk({nm, " early rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            #1;
            chk({nm, " pe_opcode wait"}, bus.pe_opcode, 32'h0);
            chk({nm, " wait rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        chk({nm, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({nm, " rsp_id"}, 32'(bus.rsp_id), 32'(id));
        chk({nm, " rsp_data"}, bus.rsp_data, exp_data);
        chk({nm, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        $display("op %s id=%0d opc=%08h a=%0h b=%0h -> data=%0h err=%0b",
                 nm, id, opc, a, b, bus.rsp_data, bus.rsp_err);
    endtask

    initial begin
        int exp_g [5];
        int exp_d [5];
        int ng;
        int nr;
        int last_g;
        int gidx;
        bit got;

        vecs[0] = '{id: 0, opc: OP_ADD,        a: 32'd10,        b: 32'd20,        err: 1'b0, data: 32'd30};
        vecs[1] = '{id: 2, opc: OP_SUB,        a: 32'd50,        b: 32'd20,        err: 1'b0, data: 32'd30};
        vecs[2] = '{id: 3, opc: OP_MUL,        a: 32'd10,        b: 32'd5,         err: 1'b0, data: 32'd50};
        vecs[3] = '{id: 1, opc: OP_SUB,        a: 32'd5,         b: 32'd7,         err: 1'b0, data: 32'hFFFF_FFFE};
        vecs[4] = '{id: 0, opc: OP_MUL,        a: 32'h0001_0000, b: 32'h0001_0000, err: 1'b0, data: 32'h0};
        vecs[5] = '{id: 3, opc: OP_ADD,        a: 32'hFFFF_FFFF, b: 32'd1,         err: 1'b0, data: 32'h0};
        vecs[6] = '{id: 2, opc: 32'h0210_00FF, a: 32'd3,         b: 32'd4,         err: 1'b0, data: 32'd7};
        vecs[7] = '{id: 1, opc: 32'h0410_0000, a: 32'd1,         b: 32'd2,         err: 1'b1, data: 32'h0};
        vecs[8] = '{id: 0, opc: 32'h0200_0000, a: 32'd1,         b: 32'd2,         err: 1'b1, data: 32'h0};
        vecs[9] = '{id: 2, opc: 32'h0240_0000, a: 32'd1,         b: 32'd2,         err: 1'b1, data: 32'h0};

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_opcode = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset pe_opcode", bus.pe_opcode, 32'h0);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset rsp_data", bus.rsp_data, 32'h0);
        chk("reset rsp_id", 32'(bus.rsp_id), 32'd0);
`ifdef PE_ARB_PERF_EN
        chk("reset perf_issue", perf_issue_cnt, 32'd0);
        chk("reset perf_err", perf_err_cnt, 32'd0);
`endif

        // Round robin with all four requesters valid, starting from the reset pointer.
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{3, 7, 30, 42, 3};
        @(negedge clk);
        set_req(0, OP_ADD, 32'd1, 32'd2);
        set_req(1, OP_ADD, 32'd3, 32'd4);
        set_req(2, OP_SUB, 32'd50, 32'd20);
        set_req(3, OP_MUL, 32'd6, 32'd7);
        ng = 0;
        nr = 0;
        last_g = 0;
        for (int cyc = 0; cyc < 40 && nr < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ng >= 5) bus.req_valid = '0;
            #1;
            if (bus.req_ready != '0) begin
                gidx = -1;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gidx = i;
                chk("rr onehot", 32'($onehot(bus.req_ready)), 32'd1);
                if (ng < 5) begin
                    chk($sformatf("rr grant %0d", ng), 32'(gidx), 32'(exp_g[ng]));
                    if (ng > 0) chk($sformatf("rr spacing %0d", ng), 32'(cyc - last_g), 32'd3);
                end else begin
                    chk("rr extra grant", 32'(ng), 32'd4);
                end
                last_g = cyc;
                ng++;
            end
            if (bus.rsp_valid) begin
                if (nr < 5) begin
                    chk($sformatf("rr rsp_id %0d", nr), 32'(bus.rsp_id), 32'(exp_g[nr]));
                    chk($sformatf("rr rsp_data %0d", nr), bus.rsp_data, 32'(exp_d[nr]));
                    $display("rr rsp id=%0d data=%0d", bus.rsp_id, bus.rsp_data);
                end
                nr++;
            end
        end
        chk("rr responses", 32'(nr), 32'd5);
        bus.req_valid = '0;

        for (int v = 0; v < 10; v++) begin
            run_op($sformatf("v%0d", v), vecs[v].id, vecs[v].opc, vecs[v].a, vecs[v].b,
                   vecs[v].err, vecs[v].data);
        end

        // Backpressure: response held while rsp_ready is low, then same-cycle re-grant.
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        set_req(0, OP_MUL, 32'd10, 32'd5);
        wait_grant(0, got);
        chk("bp grant", 32'(got), 32'd1);
        @(negedge clk);
        clr_req(0);
        set_req(1, OP_ADD, 32'd8, 32'd9);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp hold valid %0d", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp hold data %0d", i), bus.rsp_data, 32'd50);
            chk($sformatf("bp hold id %0d", i), 32'(bus.rsp_id), 32'd0);
            chk($sformatf("bp no ready %0d", i), 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp accept grant", 32'(bus.req_ready), 32'b0010);
        $display("bp rsp id=%0d data=%0d", bus.rsp_id, bus.rsp_data);
        @(negedge clk);
        clr_req(1);
        repeat (2) @(negedge clk);
        #1;
        chk("bp next valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp next id", 32'(bus.rsp_id), 32'd1);
        chk("bp next data", bus.rsp_data, 32'd17);

        // Reset during WAIT: op dropped, pointer back to NREQ-1 so req0 beats req1.
        @(negedge clk);
        set_req(0, OP_ADD, 32'd100, 32'd23);
        wait_grant(0, got);
        chk("rst grant", 32'(got), 32'd1);
        @(negedge clk);
        set_req(1, OP_SUB, 32'd9, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst pe_opcode", bus.pe_opcode, 32'h0);
        chk("rst req_ready held", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst regrant req0", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        clr_req(0);
        clr_req(1);
        #1;
        chk("rst reissue opcode", bus.pe_opcode, OP_ADD);
        repeat (2) @(negedge clk);
        #1;
        chk("rst rsp_valid after", 32'(bus.rsp_valid), 32'd1);
        chk("rst rsp_id after", 32'(bus.rsp_id), 32'd0);
        chk("rst rsp_data after", bus.rsp_data, 32'd123);
        $display("rst rsp id=%0d data=%0d", bus.rsp_id, bus.rsp_data);

        // Counters restarted at the reset above: one legal op so far.
        run_op("p0", 1, OP_ADD, 32'd2, 32'd2, 1'b0, 32'd4);
        run_op("p1", 2, 32'h0600_0000, 32'd0, 32'd0, 1'b1, 32'h0);
        run_op("p2", 3, OP_SUB, 32'd9, 32'd9, 1'b0, 32'd0);
        run_op("p3", 0, 32'h0250_0000, 32'd0, 32'd0, 1'b1, 32'h0);
`ifdef PE_ARB_PERF_EN
        @(negedge clk);
        chk("perf_issue_cnt", perf_issue_cnt, 32'd3);
        chk("perf_err_cnt", perf_err_cnt, 32'd2);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
